// File: rtl/complex_pipeline_pkg.sv
// Shared widths, depths and ALU opcodes for the four-stage complex_pipeline.
package complex_pipeline_pkg;
    localparam int DATA_W    = 16;
    localparam int REG_DEPTH = 16;
    localparam int MEM_DEPTH = 256;
    localparam int REG_AW    = 4;
    localparam int MEM_AW    = 8;
    localparam int FUNC_W    = 4;

    localparam logic [FUNC_W-1:0] FN_ADD  = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB  = 4'd1;
    localparam logic [FUNC_W-1:0] FN_MUL  = 4'd2;
    localparam logic [FUNC_W-1:0] FN_PA   = 4'd3;
    localparam logic [FUNC_W-1:0] FN_PB   = 4'd4;
    localparam logic [FUNC_W-1:0] FN_AND  = 4'd5;
    localparam logic [FUNC_W-1:0] FN_OR   = 4'd6;
    localparam logic [FUNC_W-1:0] FN_XOR  = 4'd7;
    localparam logic [FUNC_W-1:0] FN_NOTA = 4'd8;
    localparam logic [FUNC_W-1:0] FN_NOTB = 4'd9;
    localparam logic [FUNC_W-1:0] FN_SHR  = 4'd10;
    localparam logic [FUNC_W-1:0] FN_SHL  = 4'd11;
endpackage

// File: rtl/complex_pipeline_alu.sv
// Combinational ALU; results wrap modulo 2^16, unused opcodes yield zero.
module complex_pipeline_alu
    import complex_pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] result
);
    always_comb begin
        result = '0;
        case (func)
            FN_ADD:  result = a + b;
            FN_SUB:  result = a - b;
            FN_MUL:  result = a * b;
            FN_PA:   result = a;
            FN_PB:   result = b;
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_XOR:  result = a ^ b;
            FN_NOTA: result = ~a;
            FN_NOTB: result = ~b;
            FN_SHR:  result = a >> 1;
            FN_SHL:  result = a << 1;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/complex_pipeline.sv
// Four-stage pipeline: operand fetch, execute (Z), register write-back, memory store.
// Handshake: no ready; an instruction is taken every cycle in_valid is high and rst is low.
module complex_pipeline
    import complex_pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [MEM_AW-1:0] addr,
    output logic [DATA_W-1:0] Z
);
    logic [DATA_W-1:0] regbank [0:REG_DEPTH-1];
    logic [DATA_W-1:0] mem     [0:MEM_DEPTH-1];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [REG_AW-1:0] s1_rd;
    logic [FUNC_W-1:0] s1_func;
    logic [MEM_AW-1:0] s1_addr;

    logic              s2_valid;
    logic [REG_AW-1:0] s2_rd;
    logic [MEM_AW-1:0] s2_addr;

    logic              s3_valid;
    logic [DATA_W-1:0] s3_result;
    logic [MEM_AW-1:0] s3_addr;

    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] fetch_a;
    logic [DATA_W-1:0] fetch_b;
    logic              reg_we;
    logic              mem_we;

    // Writes are suppressed under reset so in-flight work is discarded.
    assign reg_we = s2_valid && !rst;
    assign mem_we = s3_valid && !rst;

    // Write-first bypass from the write-back stage only; execute is never forwarded.
    always_comb begin
        fetch_a = regbank[rs1];
        fetch_b = regbank[rs2];
        if (reg_we && (s2_rd == rs1)) fetch_a = Z;
        if (reg_we && (s2_rd == rs2)) fetch_b = Z;
    end

    complex_pipeline_alu u_alu (
        .a      (s1_a),
        .b      (s1_b),
        .func   (s1_func),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_rd     <= '0;
            s1_func   <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_rd     <= '0;
            s2_addr   <= '0;
            Z         <= '0;
            s3_valid  <= 1'b0;
            s3_result <= '0;
            s3_addr   <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_a      <= fetch_a;
            s1_b      <= fetch_b;
            s1_rd     <= rd;
            s1_func   <= func;
            s1_addr   <= addr;
            s2_valid  <= s1_valid;
            s2_rd     <= s1_rd;
            s2_addr   <= s1_addr;
            Z         <= alu_result;
            s3_valid  <= s2_valid;
            s3_result <= Z;
            s3_addr   <= s2_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reg_we) regbank[s2_rd] <= Z;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[s3_addr] <= s3_result;
    end
endmodule

// File: tb/tb_complex_pipeline.sv
// Directed bench for complex_pipeline: latency, bypass, opcode sweep, reset and bubbles.
module tb_complex_pipeline;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  rs1 = '0;
    logic [3:0]  rs2 = '0;
    logic [3:0]  rd = '0;
    logic [3:0]  func = '0;
    logic [7:0]  addr = '0;
    logic [15:0] Z;

    int vectors = 0;
    int miscompares = 0;

    complex_pipeline dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .func     (func),
        .addr     (addr),
        .Z        (Z)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] d, input logic [3:0] f, input logic [7:0] ad);
        in_valid = v;
        rs1 = a1;
        rs2 = a2;
        rd = d;
        func = f;
        addr = ad;
    endtask

    task automatic drive_idle();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int k = 0; k < 16; k++) dut.regbank[k] = 16'(k);
        for (int k = 0; k < 256; k++) dut.mem[k] = 16'hA5A5;
    endtask

    task automatic test_reset();
        preload();
        rst = 1'b1;
        drive(1'b1, 4'd1, 4'd2, 4'd5, 4'd0, 8'd5);
        step();
        step();
        vectors++;
        if (Z !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_z: got %h want 0000", Z);
        end
        rst = 1'b0;
        drive_idle();
        repeat (4) step();
        vectors++;
        if (dut.regbank[5] !== 16'd5) begin
            miscompares++;
            $display("FAIL reset_ignore_reg: got %h want 0005", dut.regbank[5]);
        end
        vectors++;
        if (dut.mem[5] !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL reset_ignore_mem: got %h want a5a5", dut.mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_z [0:3];
        logic [7:0]  m_addr [0:5];
        logic [15:0] m_exp  [0:5];
        exp_z = '{16'd8, 16'd24, 16'd3, 16'd14};
        m_addr = '{8'd125, 8'd126, 8'd128, 8'd127, 8'd129, 8'd130};
        m_exp  = '{16'd8, 16'd24, 16'd3, 16'd14, 16'hA5A5, 16'hA5A5};
        preload();
        drive(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        step();
        drive(1'b1, 4'd3, 4'd8, 4'd12, 4'd2, 8'd126);
        step();
        vectors++;
        if (Z !== exp_z[0]) begin miscompares++; $display("FAIL b2b_z0: got %h want %h", Z, exp_z[0]); end
        drive(1'b1, 4'd10, 4'd5, 4'd14, 4'd1, 8'd128);
        step();
        vectors++;
        if (Z !== exp_z[1]) begin miscompares++; $display("FAIL b2b_z1: got %h want %h", Z, exp_z[1]); end
        drive(1'b1, 4'd7, 4'd3, 4'd13, 4'd11, 8'd127);
        step();
        vectors++;
        if (Z !== exp_z[2]) begin miscompares++; $display("FAIL b2b_z2_bypass: got %h want %h", Z, exp_z[2]); end
        drive_idle();
        step();
        vectors++;
        if (Z !== exp_z[3]) begin miscompares++; $display("FAIL b2b_z3: got %h want %h", Z, exp_z[3]); end
        repeat (3) step();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (dut.mem[m_addr[i]] !== m_exp[i]) begin
                miscompares++;
                $display("FAIL b2b_mem[%0d]: got %h want %h", m_addr[i], dut.mem[m_addr[i]], m_exp[i]);
            end
        end
        vectors++;
        if (dut.regbank[14] !== 16'd3) begin
            miscompares++;
            $display("FAIL b2b_reg14: got %h want 0003", dut.regbank[14]);
        end
        vectors++;
        if (dut.regbank[13] !== 16'd14) begin
            miscompares++;
            $display("FAIL b2b_reg13: got %h want 000e", dut.regbank[13]);
        end
    endtask

    task automatic test_no_forward();
        preload();
        drive(1'b1, 4'd1, 4'd1, 4'd2, 4'd0, 8'd10);
        step();
        drive(1'b1, 4'd2, 4'd1, 4'd3, 4'd0, 8'd11);
        step();
        vectors++;
        if (Z !== 16'd2) begin miscompares++; $display("FAIL nofwd_z0: got %h want 0002", Z); end
        drive_idle();
        step();
        vectors++;
        if (Z !== 16'd3) begin miscompares++; $display("FAIL nofwd_z1_stale: got %h want 0003", Z); end
        repeat (3) step();
        vectors++;
        if (dut.mem[10] !== 16'd2) begin miscompares++; $display("FAIL nofwd_mem10: got %h want 0002", dut.mem[10]); end
        vectors++;
        if (dut.mem[11] !== 16'd3) begin miscompares++; $display("FAIL nofwd_mem11: got %h want 0003", dut.mem[11]); end
    endtask

    task automatic test_opcode_sweep();
        logic [15:0] exp_r [0:15];
        exp_r = '{16'hF10E, 16'hEF10, 16'h1EF1, 16'hF00F, 16'h00FF, 16'h000F, 16'hF0FF, 16'hF0F0,
                  16'h0FF0, 16'hFF00, 16'h7807, 16'hE01E, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        preload();
        dut.regbank[4] = 16'hF00F;
        dut.regbank[5] = 16'h00FF;
        drive(1'b1, 4'd4, 4'd5, 4'd15, 4'd0, 8'd200);
        step();
        for (int f = 1; f <= 16; f++) begin
            if (f < 16) drive(1'b1, 4'd4, 4'd5, 4'd15, 4'(f), 8'(200 + f));
            else drive_idle();
            step();
            vectors++;
            if (Z !== exp_r[f-1]) begin
                miscompares++;
                $display("FAIL sweep_z func %0d: got %h want %h", f - 1, Z, exp_r[f-1]);
            end
        end
        repeat (3) step();
        for (int f = 0; f < 16; f++) begin
            vectors++;
            if (dut.mem[200 + f] !== exp_r[f]) begin
                miscompares++;
                $display("FAIL sweep_mem func %0d: got %h want %h", f, dut.mem[200 + f], exp_r[f]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0]  r_idx [0:3];
        logic [15:0] r_exp [0:3];
        preload();
        dut.regbank[6] = 16'h0666;
        r_idx = '{4'd6, 4'd7, 4'd8, 4'd11};
        r_exp = '{16'h0666, 16'd7, 16'd8, 16'd11};
        // First instruction copies regbank[6] onto itself, so its retired write leaves no trace.
        drive(1'b1, 4'd6, 4'd0, 4'd6, 4'd3, 8'd50);
        step();
        drive(1'b1, 4'd1, 4'd2, 4'd7, 4'd0, 8'd51);
        step();
        drive(1'b1, 4'd1, 4'd1, 4'd8, 4'd0, 8'd52);
        step();
        rst = 1'b1;
        drive(1'b1, 4'd1, 4'd2, 4'd11, 4'd0, 8'd54);
        step();
        vectors++;
        if (Z !== 16'h0000) begin miscompares++; $display("FAIL midrst_z: got %h want 0000", Z); end
        rst = 1'b0;
        drive_idle();
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut.regbank[r_idx[i]] !== r_exp[i]) begin
                miscompares++;
                $display("FAIL midrst_reg[%0d]: got %h want %h", r_idx[i], dut.regbank[r_idx[i]], r_exp[i]);
            end
        end
        for (int a = 50; a <= 54; a++) begin
            vectors++;
            if (dut.mem[a] !== 16'hA5A5) begin
                miscompares++;
                $display("FAIL midrst_mem[%0d]: got %h want a5a5", a, dut.mem[a]);
            end
        end
        drive(1'b1, 4'd1, 4'd2, 4'd9, 4'd0, 8'd53);
        step();
        drive_idle();
        step();
        vectors++;
        if (Z !== 16'd3) begin miscompares++; $display("FAIL midrst_after_z: got %h want 0003", Z); end
        repeat (3) step();
        vectors++;
        if (dut.regbank[9] !== 16'd3) begin miscompares++; $display("FAIL midrst_after_reg9: got %h want 0003", dut.regbank[9]); end
        vectors++;
        if (dut.mem[53] !== 16'd3) begin miscompares++; $display("FAIL midrst_after_mem53: got %h want 0003", dut.mem[53]); end
    endtask

    task automatic test_bubble();
        preload();
        dut.regbank[0] = 16'h1234;
        dut.regbank[3] = 16'h0100;
        dut.mem[0] = 16'h5678;
        drive(1'b0, 4'd0, 4'd3, 4'd0, 4'd0, 8'd0);
        step();
        step();
        vectors++;
        if (Z !== 16'h1334) begin miscompares++; $display("FAIL bubble_z: got %h want 1334", Z); end
        drive_idle();
        repeat (3) step();
        vectors++;
        if (dut.regbank[0] !== 16'h1234) begin miscompares++; $display("FAIL bubble_reg0: got %h want 1234", dut.regbank[0]); end
        vectors++;
        if (dut.mem[0] !== 16'h5678) begin miscompares++; $display("FAIL bubble_mem0: got %h want 5678", dut.mem[0]); end
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_no_forward();
        test_opcode_sweep();
        test_reset_midflight();
        test_bubble();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
